// File: rtl/cw_responder.sv
// -----------------------------------------------------------------------------
// cw_responder
//
// Far-end responder for the 16-bit bidirectional chip-to-chip "cw" bus. It runs
// on the forwarded cw clock, receives a request frame (header, address word and,
// for writes, a data word), executes it as a single Wishbone-style access on
// the local bus and returns the read data, or a write completion, on the
// shared pins once the initiator has turned the bus around.
//
// Frame words (one per clock while i_cw_req=1 and i_cw_dir=0):
//   W0 header : [15] we, [14:8] ignored, [7:0] adr[23:16]
//   W1        : adr[15:0]
//   W2        : write data (writes only)
//
// Ports
//   i_clk       forwarded cw clock
//   i_rst_n     asynchronous active-low reset
//   i_cw_req    initiator request, high for the whole transaction
//   i_cw_dir    0 = initiator drives the pins, 1 = responder may drive
//   i_cw_data   pin input data
//   o_cw_data   pin output data (read data / 0x0000 for writes)
//   o_cw_oe     responder drive enable, only ever high while i_cw_dir=1
//   o_cw_ack    one-cycle response strobe
//   o_cw_err    error flag, valid with o_cw_ack
//   o_wb_cyc    local bus cycle
//   o_wb_stb    local bus strobe
//   o_wb_we     local bus write enable
//   o_wb_adr    local bus address
//   o_wb_dat    local bus write data
//   i_wb_dat    local bus read data
//   i_wb_ack    local bus acknowledge
//   i_wb_err    local bus error (wins over a simultaneous ack)
// -----------------------------------------------------------------------------
module cw_responder #(
    parameter int ADDR_W  = 24,
    parameter int TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cw_req,
    input  logic              i_cw_dir,
    input  logic [15:0]       i_cw_data,
    output logic [15:0]       o_cw_data,
    output logic              o_cw_oe,
    output logic              o_cw_ack,
    output logic              o_cw_err,
    output logic              o_wb_cyc,
    output logic              o_wb_stb,
    output logic              o_wb_we,
    output logic [ADDR_W-1:0] o_wb_adr,
    output logic [15:0]       o_wb_dat,
    input  logic [15:0]       i_wb_dat,
    input  logic              i_wb_ack,
    input  logic              i_wb_err
);

    // Last counter value of a silent access: the access is abandoned at the
    // end of the TIMEOUT-th bus cycle, so cyc stays high for TIMEOUT cycles.
    localparam logic [7:0] TMO_LAST_C = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_DATA     = 3'd2,
        ST_BUS      = 3'd3,
        ST_WAIT_DIR = 3'd4,
        ST_RESP     = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    state_t              state_r;

    // Captured frame contents
    logic                hdr_we_r;
    logic [7:0]          adr_hi_r;
    logic [15:0]         adr_lo_r;

    // Bus access bookkeeping
    logic [7:0]          tmo_cnt_r;
    logic                abort_r;
    logic                bus_err_r;
    logic [15:0]         rdat_r;

    // Registered outputs
    logic                cw_oe_r;
    logic                cw_ack_r;
    logic                cw_err_r;
    logic [15:0]         cw_data_r;
    logic                wb_cyc_r;
    logic                wb_stb_r;
    logic                wb_we_r;
    logic [ADDR_W-1:0]   wb_adr_r;
    logic [15:0]         wb_dat_r;

    // Helper terms
    logic                abort_s;
    logic                bus_resp_s;
    logic                tmo_hit_s;
    logic                hdr_unused_s;

    // The initiator has given up on this transaction if req is low now or was
    // seen low at any earlier point of the bus access.
    assign abort_s      = abort_r | ~i_cw_req;
    assign bus_resp_s   = i_wb_ack | i_wb_err;
    assign tmo_hit_s    = (tmo_cnt_r == TMO_LAST_C);
    // Header bits [14:8] carry no meaning for this responder.
    assign hdr_unused_s = ^i_cw_data[14:8];

    // Main transaction FSM; every output is registered here.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r   <= ST_IDLE;
            hdr_we_r  <= 1'b0;
            adr_hi_r  <= 8'h00;
            adr_lo_r  <= 16'h0000;
            tmo_cnt_r <= 8'h00;
            abort_r   <= 1'b0;
            bus_err_r <= 1'b0;
            rdat_r    <= 16'h0000;
            cw_oe_r   <= 1'b0;
            cw_ack_r  <= 1'b0;
            cw_err_r  <= 1'b0;
            cw_data_r <= 16'h0000;
            wb_cyc_r  <= 1'b0;
            wb_stb_r  <= 1'b0;
            wb_we_r   <= 1'b0;
            wb_adr_r  <= '0;
            wb_dat_r  <= 16'h0000;
        end else begin
            // Response outputs are single-cycle pulses unless set below.
            cw_oe_r   <= 1'b0;
            cw_ack_r  <= 1'b0;
            cw_err_r  <= 1'b0;
            cw_data_r <= 16'h0000;

            case (state_r)
                ST_IDLE: begin
                    if (i_cw_req && !i_cw_dir) begin
                        hdr_we_r <= i_cw_data[15];
                        adr_hi_r <= i_cw_data[7:0];
                        abort_r  <= 1'b0;
                        state_r  <= ST_ADDR;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end

                ST_ADDR: begin
                    // Request withdrawn, or the initiator turned the bus
                    // around mid-frame: drop the frame without any access.
                    if (!i_cw_req || i_cw_dir) begin
                        state_r <= ST_IDLE;
                    end else if (hdr_we_r) begin
                        adr_lo_r <= i_cw_data;
                        state_r  <= ST_DATA;
                    end else begin
                        adr_lo_r  <= i_cw_data;
                        wb_cyc_r  <= 1'b1;
                        wb_stb_r  <= 1'b1;
                        wb_we_r   <= 1'b0;
                        wb_adr_r  <= {adr_hi_r, i_cw_data};
                        tmo_cnt_r <= 8'h00;
                        state_r   <= ST_BUS;
                    end
                end

                ST_DATA: begin
                    if (!i_cw_req || i_cw_dir) begin
                        state_r <= ST_IDLE;
                    end else begin
                        wb_cyc_r  <= 1'b1;
                        wb_stb_r  <= 1'b1;
                        wb_we_r   <= 1'b1;
                        wb_adr_r  <= {adr_hi_r, adr_lo_r};
                        wb_dat_r  <= i_cw_data;
                        tmo_cnt_r <= 8'h00;
                        state_r   <= ST_BUS;
                    end
                end

                ST_BUS: begin
                    if (bus_resp_s) begin
                        // Error has priority over a simultaneous ack.
                        wb_cyc_r  <= 1'b0;
                        wb_stb_r  <= 1'b0;
                        wb_we_r   <= 1'b0;
                        bus_err_r <= i_wb_err;
                        rdat_r    <= hdr_we_r ? 16'h0000 : i_wb_dat;
                        state_r   <= abort_s ? ST_IDLE : ST_WAIT_DIR;
                    end else if (tmo_hit_s) begin
                        wb_cyc_r  <= 1'b0;
                        wb_stb_r  <= 1'b0;
                        wb_we_r   <= 1'b0;
                        bus_err_r <= 1'b1;
                        rdat_r    <= 16'h0000;
                        state_r   <= abort_s ? ST_IDLE : ST_WAIT_DIR;
                    end else begin
                        // A started access always runs to completion; only
                        // remember that nobody will collect the response.
                        tmo_cnt_r <= tmo_cnt_r + 8'd1;
                        abort_r   <= abort_s;
                        state_r   <= ST_BUS;
                    end
                end

                ST_WAIT_DIR: begin
                    if (!i_cw_req) begin
                        state_r <= ST_IDLE;
                    end else if (i_cw_dir) begin
                        cw_oe_r   <= 1'b1;
                        cw_ack_r  <= 1'b1;
                        cw_err_r  <= bus_err_r;
                        cw_data_r <= rdat_r;
                        state_r   <= ST_RESP;
                    end else begin
                        state_r <= ST_WAIT_DIR;
                    end
                end

                ST_RESP: begin
                    state_r <= ST_DONE;
                end

                ST_DONE: begin
                    // Back-to-back frames need req to fall for a cycle first.
                    if (!i_cw_req) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end

                default: begin
                    wb_cyc_r <= 1'b0;
                    wb_stb_r <= 1'b0;
                    wb_we_r  <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    // Pad enable is gated by the live dir pin so the responder can never
    // fight the initiator, even for the cycle in which dir falls.
    assign o_cw_oe   = cw_oe_r & i_cw_dir;
    assign o_cw_data = cw_data_r;
    assign o_cw_ack  = cw_ack_r;
    assign o_cw_err  = cw_err_r;
    assign o_wb_cyc  = wb_cyc_r;
    assign o_wb_stb  = wb_stb_r;
    assign o_wb_we   = wb_we_r;
    assign o_wb_adr  = wb_adr_r;
    assign o_wb_dat  = wb_dat_r;

endmodule

// File: tb/tb_cw_responder.sv
// -----------------------------------------------------------------------------
// Self-checking bench for cw_responder: a directed vector table, hand-written
// abort / reset sequences and randomized transactions whose expectations come
// from a phase-counting model of the protocol.
// -----------------------------------------------------------------------------
module tb_cw_responder;

    logic        clk;
    logic        rst_n;
    logic        cw_req;
    logic        cw_dir;
    logic [15:0] cw_din;
    logic [15:0] cw_dout;
    logic        cw_oe;
    logic        cw_ack;
    logic        cw_err;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [23:0] wb_adr;
    logic [15:0] wb_dat;
    logic [15:0] wb_rdat;
    logic        wb_ack;
    logic        wb_err;

    int errors = 0;
    int checks = 0;

    cw_responder #(.ADDR_W(24), .TIMEOUT(255)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_cw_req  (cw_req),
        .i_cw_dir  (cw_dir),
        .i_cw_data (cw_din),
        .o_cw_data (cw_dout),
        .o_cw_oe   (cw_oe),
        .o_cw_ack  (cw_ack),
        .o_cw_err  (cw_err),
        .o_wb_cyc  (wb_cyc),
        .o_wb_stb  (wb_stb),
        .o_wb_we   (wb_we),
        .o_wb_adr  (wb_adr),
        .o_wb_dat  (wb_dat),
        .i_wb_dat  (wb_rdat),
        .i_wb_ack  (wb_ack),
        .i_wb_err  (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave response kinds
    localparam int K_ACK  = 0;
    localparam int K_ERR  = 1;
    localparam int K_BOTH = 2;
    localparam int K_NONE = 3;

    typedef struct {
        logic        we;
        logic [23:0] adr;
        logic [15:0] wdat;
        logic [15:0] rdat;
        int          wait_n;
        int          kind;
        int          dly;
        int          exp_cyc;
        logic [15:0] exp_data;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the response appears one cycle after the later of
    // "bus access finished" and "dir high", counted from the first bus cycle,
    // which follows the header plus one (read) or two (write) frame words.
    function automatic int model_lat(input logic we, input int bus_cycles, input int dly);
        int first_bus;
        first_bus = we ? 3 : 2;
        return first_bus + ((bus_cycles > dly) ? bus_cycles : dly) + 1;
    endfunction

    // Drive one complete transaction, act as the local slave, then check.
    task automatic do_txn(input string tag, input logic we, input logic [23:0] adr,
                          input logic [15:0] wdat, input logic [15:0] rdat,
                          input int wait_n, input int kind, input int dly,
                          input int exp_cyc, input logic [15:0] exp_data,
                          input logic exp_err, input int exp_lat);
        int          s;
        int          end_c;
        int          bus_cnt;
        int          stb_cnt;
        int          ack_cnt;
        int          oe_cnt;
        int          oe_bad;
        int          ack_at;
        logic [15:0] got_data;
        logic        got_err;
        logic [23:0] got_adr;
        logic        got_we;
        logic [15:0] got_dat;
        logic [6:0]  junk;
        s        = we ? 3 : 2;
        end_c    = exp_lat + 3;
        bus_cnt  = 0;
        stb_cnt  = 0;
        ack_cnt  = 0;
        oe_cnt   = 0;
        oe_bad   = 0;
        ack_at   = -1;
        got_data = 16'h0000;
        got_err  = 1'b0;
        got_adr  = 24'h000000;
        got_we   = 1'b0;
        got_dat  = 16'h0000;
        junk     = 7'($urandom);
        cw_req   = 1'b1;
        cw_dir   = 1'b0;
        cw_din   = {we, junk, adr[23:16]};
        for (int c = 1; c <= end_c; c++) begin
            step();
            if (c == 1) cw_din = adr[15:0];
            else if (c == 2 && we) cw_din = wdat;
            else cw_din = 16'($urandom);
            cw_dir  = (c >= s + dly);
            wb_ack  = 1'b0;
            wb_err  = 1'b0;
            wb_rdat = rdat;
            if (wb_stb) stb_cnt++;
            if (wb_cyc) begin
                if (bus_cnt == 0) begin
                    got_adr = wb_adr;
                    got_we  = wb_we;
                    got_dat = wb_dat;
                end
                if (bus_cnt == wait_n) begin
                    wb_ack = (kind == K_ACK) || (kind == K_BOTH);
                    wb_err = (kind == K_ERR) || (kind == K_BOTH);
                end
                bus_cnt++;
            end
            #1;
            if (cw_oe) oe_cnt++;
            if (cw_oe && !cw_dir) oe_bad++;
            if (cw_ack) begin
                ack_cnt++;
                ack_at   = c;
                got_data = cw_dout;
                got_err  = cw_err;
            end
        end
        cw_req = 1'b0;
        cw_dir = 1'b0;
        wb_ack = 1'b0;
        wb_err = 1'b0;
        step();
        step();
        chk($sformatf("%s_cyc_cycles", tag), 32'(bus_cnt), 32'(exp_cyc));
        chk($sformatf("%s_stb_cycles", tag), 32'(stb_cnt), 32'(exp_cyc));
        chk($sformatf("%s_adr", tag), 32'(got_adr), 32'(adr));
        chk($sformatf("%s_we", tag), 32'(got_we), 32'(we));
        if (we) chk($sformatf("%s_wdat", tag), 32'(got_dat), 32'(wdat));
        chk($sformatf("%s_ack_count", tag), 32'(ack_cnt), 32'd1);
        chk($sformatf("%s_ack_latency", tag), 32'(ack_at), 32'(exp_lat));
        chk($sformatf("%s_rdata", tag), 32'(got_data), 32'(exp_data));
        chk($sformatf("%s_err", tag), 32'(got_err), 32'(exp_err));
        chk($sformatf("%s_oe_count", tag), 32'(oe_cnt), 32'd1);
        chk($sformatf("%s_oe_without_dir", tag), 32'(oe_bad), 32'd0);
        chk($sformatf("%s_idle_cyc", tag), 32'(wb_cyc), 32'd0);
    endtask

    // Transactions the initiator abandons; none may produce a response.
    //   mode 0: write, req dropped after W1
    //   mode 1: read, req dropped during the bus access (slave acks late)
    //   mode 2: read, dir raised during the address word
    //   mode 3: read, req dropped while waiting for dir
    task automatic do_abort(input string tag, input int mode, input int exp_cyc);
        int   cyc_cnt;
        int   ack_cnt;
        int   oe_cnt;
        logic we;
        cyc_cnt = 0;
        ack_cnt = 0;
        oe_cnt  = 0;
        we      = (mode == 0);
        cw_req  = 1'b1;
        cw_dir  = 1'b0;
        cw_din  = {we, 7'h55, 8'h3C};
        for (int c = 1; c <= 10; c++) begin
            step();
            cw_din  = (c == 1) ? 16'h7788 : 16'h99AA;
            wb_rdat = 16'hDEAD;
            case (mode)
                0: begin cw_req = (c < 2); cw_dir = 1'b0; end
                1: begin cw_req = (c < 3); cw_dir = (c == 2); end
                2: begin cw_req = (c < 3); cw_dir = (c == 1) || (c == 2); end
                default: begin cw_req = (c < 5); cw_dir = 1'b0; end
            endcase
            wb_ack = 1'b0;
            wb_err = 1'b0;
            if (wb_cyc) begin
                wb_ack = (cyc_cnt == ((mode == 1) ? 3 : 0));
                cyc_cnt++;
            end
            #1;
            if (cw_ack) ack_cnt++;
            if (cw_oe) oe_cnt++;
        end
        cw_req = 1'b0;
        cw_dir = 1'b0;
        wb_ack = 1'b0;
        step();
        chk($sformatf("%s_cyc_cycles", tag), 32'(cyc_cnt), 32'(exp_cyc));
        chk($sformatf("%s_no_ack", tag), 32'(ack_cnt), 32'd0);
        chk($sformatf("%s_no_oe", tag), 32'(oe_cnt), 32'd0);
    endtask

    // Reset pulse in the middle of a silent bus access.
    task automatic seq_reset_mid_bus();
        cw_req = 1'b1;
        cw_dir = 1'b0;
        cw_din = 16'h0042;
        step();
        cw_din = 16'h1000;
        step();
        cw_din = 16'h0000;
        cw_dir = 1'b1;
        step();
        step();
        chk("rst_pre_cyc", 32'(wb_cyc), 32'd1);
        chk("rst_pre_adr", 32'(wb_adr), 32'h421000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_cyc", 32'(wb_cyc), 32'd0);
        chk("rst_async_stb", 32'(wb_stb), 32'd0);
        chk("rst_async_oe", 32'(cw_oe), 32'd0);
        chk("rst_async_ack", 32'(cw_ack), 32'd0);
        cw_req = 1'b0;
        cw_dir = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        chk("rst_after_cyc", 32'(wb_cyc), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        cw_req  = 1'b0;
        cw_dir  = 1'b0;
        cw_din  = 16'h0000;
        wb_rdat = 16'h0000;
        wb_ack  = 1'b0;
        wb_err  = 1'b0;

        //          we    adr         wdat      rdat     wait kind   dly cyc data      err  lat
        vecs[0] = '{1'b0, 24'h123456, 16'h0000, 16'hBEEF, 2, K_ACK,  0, 3,   16'hBEEF, 1'b0, 6};
        vecs[1] = '{1'b1, 24'h010002, 16'hA5A5, 16'hFFFF, 0, K_ACK,  0, 1,   16'h0000, 1'b0, 5};
        vecs[2] = '{1'b0, 24'hABCDEF, 16'h0000, 16'h5A5A, 0, K_BOTH, 0, 1,   16'h5A5A, 1'b1, 4};
        vecs[3] = '{1'b0, 24'h00F00D, 16'h0000, 16'h1111, 0, K_NONE, 0, 255, 16'h0000, 1'b1, 258};
        vecs[4] = '{1'b0, 24'hFFFFFF, 16'h0000, 16'hC3C3, 0, K_ACK,  5, 1,   16'hC3C3, 1'b0, 8};
        vecs[5] = '{1'b1, 24'h800001, 16'h1234, 16'hEEEE, 1, K_ERR,  0, 2,   16'h0000, 1'b1, 6};
        vecs[6] = '{1'b1, 24'h000000, 16'hFFFF, 16'h0F0F, 3, K_ACK,  2, 4,   16'h0000, 1'b0, 8};

        // Reset state
        #12;
        chk("reset_cyc", 32'(wb_cyc), 32'd0);
        chk("reset_stb", 32'(wb_stb), 32'd0);
        chk("reset_we", 32'(wb_we), 32'd0);
        chk("reset_adr", 32'(wb_adr), 32'd0);
        chk("reset_dat", 32'(wb_dat), 32'd0);
        chk("reset_oe", 32'(cw_oe), 32'd0);
        chk("reset_ack", 32'(cw_ack), 32'd0);
        chk("reset_err", 32'(cw_err), 32'd0);
        chk("reset_cw_data", 32'(cw_dout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Directed vector table
        for (int i = 0; i < 7; i++) begin
            do_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].adr, vecs[i].wdat,
                   vecs[i].rdat, vecs[i].wait_n, vecs[i].kind, vecs[i].dly,
                   vecs[i].exp_cyc, vecs[i].exp_data, vecs[i].exp_err, vecs[i].exp_lat);
        end

        // Abandoned transactions, each followed by a normal read
        do_abort("abort_data", 0, 0);
        do_txn("post_abort_data", 1'b0, 24'h0A0B0C, 16'h0000, 16'h1357, 1, K_ACK, 0,
               2, 16'h1357, 1'b0, 5);
        do_abort("abort_bus", 1, 4);
        do_txn("post_abort_bus", 1'b0, 24'h102030, 16'h0000, 16'h2468, 0, K_ACK, 0,
               1, 16'h2468, 1'b0, 4);
        do_abort("abort_dir", 2, 0);
        do_txn("post_abort_dir", 1'b1, 24'h405060, 16'h3C3C, 16'h0000, 0, K_ACK, 0,
               1, 16'h0000, 1'b0, 5);
        do_abort("abort_wait", 3, 1);
        do_txn("post_abort_wait", 1'b0, 24'h7F7F7F, 16'h0000, 16'h8001, 2, K_ACK, 1,
               3, 16'h8001, 1'b0, 6);

        // Reset in the middle of a bus access, then a clean transaction
        seq_reset_mid_bus();
        do_txn("post_reset", 1'b0, 24'h123456, 16'h0000, 16'hBEEF, 2, K_ACK, 0,
               3, 16'hBEEF, 1'b0, 6);

        // Randomized transactions against the reference model
        for (int i = 0; i < 25; i++) begin
            logic        r_we;
            logic [23:0] r_adr;
            logic [15:0] r_wdat;
            logic [15:0] r_rdat;
            int          r_wait;
            int          r_kind;
            int          r_dly;
            int          e_cyc;
            r_we   = 1'($urandom_range(0, 1));
            r_adr  = 24'($urandom);
            r_wdat = 16'($urandom);
            r_rdat = 16'($urandom);
            r_wait = $urandom_range(0, 4);
            r_kind = $urandom_range(0, 2);
            r_dly  = $urandom_range(0, 6);
            e_cyc  = r_wait + 1;
            do_txn($sformatf("rnd%0d", i), r_we, r_adr, r_wdat, r_rdat, r_wait, r_kind,
                   r_dly, e_cyc, r_we ? 16'h0000 : r_rdat, (r_kind != K_ACK),
                   model_lat(r_we, e_cyc, r_dly));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cw_responder.md
Name: cw_responder

Overview:
Far-end responder for the 16-bit bidirectional chip-to-chip "cw" bus (req / dir / 16-bit data, forwarded clock).
- Runs on the forwarded cw clock.
- Receives request frames from the initiator and executes each as a single Wishbone-style access on the local bus.
- Returns read data, or write completion, on the shared pins after the initiator turns the bus around.

Parameters:
ADDR_W, 24, local bus address width (header byte + address word; must be 24)
TIMEOUT, 255, local bus cycles without ack/err before the access is aborted with error (8-bit counter)

Ports:
i_clk  input  1  forwarded cw clock
i_rst_n  input  1  asynchronous active-low reset
i_cw_req  input  1  initiator request; held high for the whole transaction
i_cw_dir  input  1  0 = initiator drives pins, 1 = responder may drive
i_cw_data  input  16  pin input data
o_cw_data  output  16  pin output data
o_cw_oe  output  1  responder drive enable (pad oeb = ~o_cw_oe)
o_cw_ack  output  1  one-cycle response strobe
o_cw_err  output  1  error flag, valid with o_cw_ack
o_wb_cyc  output  1  local bus cycle
o_wb_stb  output  1  local bus strobe
o_wb_we  output  1  local bus write enable
o_wb_adr  output  24  local bus address
o_wb_dat  output  16  local bus write data
i_wb_dat  input  16  local bus read data
i_wb_ack  input  1  local bus acknowledge
i_wb_err  input  1  local bus error

Behaviour:
- Reset (async assert, sync deassert handled upstream): state IDLE; all outputs 0; internal registers 0.
- Frame format, one word per clock while i_cw_req=1 and i_cw_dir=0:
  - W0 header: [15] we, [14:8] ignored, [7:0] adr[23:16]
  - W1: adr[15:0]
  - W2: write data (write transactions only)
- States:
  - IDLE: on i_cw_req=1 with dir=0, capture i_cw_data as W0 in the same cycle -> ADDR.
  - ADDR: capture W1 -> DATA if we, else -> BUS.
  - DATA: capture W2 -> BUS.
  - BUS: assert cyc/stb/we/adr/dat (registered) on the first BUS cycle; hold until i_wb_ack or i_wb_err. On that cycle deassert cyc/stb, latch i_wb_dat (reads) and err, -> WAIT_DIR.
  - WAIT_DIR: wait for i_cw_dir=1 -> RESP.
  - RESP: o_cw_oe=1, o_cw_data = read data (0x0000 for writes), o_cw_ack=1, o_cw_err = latched err, all for exactly one cycle -> DONE.
  - DONE: o_cw_oe=0; wait for i_cw_req=0 -> IDLE.
- Timeout: counter cleared on BUS entry, incremented each BUS cycle. When it reaches TIMEOUT with no ack/err: drop cyc/stb, set err=1, read data 0 -> WAIT_DIR.
- Simultaneous i_wb_ack and i_wb_err: err wins.
- Latency: read with zero-wait-state ack and dir already 1 gives o_cw_ack 4 cycles after W0 (ADDR, BUS, BUS-ack, WAIT_DIR pass-through, RESP); a write adds 1 cycle.
- Abort rules:
  - i_cw_req=0 in ADDR or DATA -> IDLE, no bus access, no ack.
  - i_cw_req=0 in BUS -> finish the bus access (ack/err/timeout), then -> IDLE with no response.
  - i_cw_req=0 in WAIT_DIR -> IDLE.
- Bus contention: i_cw_dir=1 while in ADDR or DATA is a protocol error -> IDLE. o_cw_oe is never asserted unless i_cw_dir=1 in the same cycle (combinational AND with the registered enable).
- New transaction requires i_cw_req low for at least one cycle (DONE -> IDLE).

Test Plan:
- Read 0x12_3456, wb acks after 2 wait cycles with 0xBEEF, dir raised immediately -> o_wb_adr=0x123456, we=0, cyc high 3 cycles; single o_cw_ack with o_cw_data=0xBEEF, err=0, oe high one cycle.
- Write header 0x8001, W1=0x0002, W2=0xA5A5, zero-wait ack -> o_wb_adr=0x010002, o_wb_dat=0xA5A5, we=1; ack with data 0x0000, err=0.
- Read, i_wb_err=1 on the same cycle as i_wb_ack -> o_cw_ack=1, o_cw_err=1.
- Read to silent slave, TIMEOUT=255 -> cyc drops after 255 BUS cycles, ack with err=1, data 0x0000.
- i_cw_req dropped after W1 of a write -> no cyc ever asserted, no ack, back in IDLE; next read completes normally.
- i_rst_n pulsed low mid-BUS with cyc high -> cyc/stb/oe/ack go 0 asynchronously and the FSM restarts cleanly on the next request.
